// File: rtl/smmha_job_sequencer_pkg.sv
// Shared types for the smmha job sequencer: the job descriptor and the sequencer FSM states.
// Address and length widths here are the defaults used by the sequencer parameters.
package smmha_package;

  localparam int SMMHA_ADDR_W = 32;
  localparam int SMMHA_LEN_W  = 32;

  typedef struct packed {
    logic [31:0]             operand;
    logic [31:0]             operation;
    logic [SMMHA_LEN_W-1:0]  len;
    logic [SMMHA_ADDR_W-1:0] in_addr;
    logic [SMMHA_ADDR_W-1:0] out_addr;
  } smmha_job_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    RUN,
    DONE
  } smmha_seq_state_e;

endpackage

// File: rtl/smmha_job_sequencer_fifo.sv
// Small job descriptor FIFO with synchronous clear; head entry is visible on data_o when non-empty.
module smmha_job_fifo
  import smmha_package::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  smmha_job_t data_i,
  output smmha_job_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  smmha_job_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_incr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o && !clear_i;
  assign w_pop   = pop_i && !empty_o && !clear_i;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_incr(r_wptr);
      if (w_pop)  r_rptr <= f_incr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/smmha_job_sequencer.sv
// smmha job sequencer: queues job descriptors, splits each into chunks and drives streamer/engine handshakes.
// Defining SMMHA_JOB_PERF_EN adds the perf_cycles_o/perf_chunks_o per-job counters.
module smmha_job_sequencer
  import smmha_package::*;
#(
  parameter int ADDR_W      = SMMHA_ADDR_W,
  parameter int LEN_W       = SMMHA_LEN_W,
  parameter int MAX_CHUNK   = 256,
  parameter int ELEM_BYTES  = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [31:0]       job_operand_i,
  input  logic [31:0]       job_operation_i,
  input  logic [LEN_W-1:0]  job_len_i,
  input  logic [ADDR_W-1:0] job_in_addr_i,
  input  logic [ADDR_W-1:0] job_out_addr_i,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic              snk_valid_o,
  input  logic              snk_ready_i,
  output logic [ADDR_W-1:0] snk_addr_o,
  output logic [LEN_W-1:0]  chunk_len_o,
  output logic              eng_start_o,
  output logic [31:0]       eng_operand_o,
  output logic [31:0]       eng_operation_o,
  input  logic              eng_done_i,
  output logic              evt_done_o,
  output logic              busy_o
`ifdef SMMHA_JOB_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o,
  output logic [15:0]       perf_chunks_o
`endif
);

  localparam int ELEM_SHIFT = $clog2(ELEM_BYTES);

  smmha_seq_state_e  r_state;
  smmha_seq_state_e  w_stateNext;
  smmha_job_t        w_fifoIn;
  smmha_job_t        w_fifoHead;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic              w_push;
  logic              w_pop;
  logic              r_rstDone;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_chunkLen;
  logic [ADDR_W-1:0] r_srcAddr;
  logic [ADDR_W-1:0] r_snkAddr;
  logic [31:0]       r_operand;
  logic [31:0]       r_operation;
  logic              r_srcValid;
  logic              r_snkValid;
  logic              r_srcDone;
  logic              r_snkDone;
  logic              r_engStart;
  logic              w_srcHs;
  logic              w_snkHs;
  logic              w_bothDone;
  logic [LEN_W-1:0]  w_remNext;
  logic [ADDR_W-1:0] w_stride;

  function automatic logic [LEN_W-1:0] f_chunk(input logic [LEN_W-1:0] rem);
    return (rem > LEN_W'(MAX_CHUNK)) ? LEN_W'(MAX_CHUNK) : rem;
  endfunction

  assign w_fifoIn = '{operand:   job_operand_i,
                      operation: job_operation_i,
                      len:       SMMHA_LEN_W'(job_len_i),
                      in_addr:   SMMHA_ADDR_W'(job_in_addr_i),
                      out_addr:  SMMHA_ADDR_W'(job_out_addr_i)};

  // Ready comes from the registered count, so a full queue never takes a push while it pops.
  assign job_ready_o = r_rstDone && !w_fifoFull;
  assign w_push      = job_valid_i && job_ready_o;
  assign w_pop       = (r_state == IDLE) && !w_fifoEmpty;

  smmha_job_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_fifoIn),
    .data_o  (w_fifoHead),
    .full_o  (w_fifoFull),
    .empty_o (w_fifoEmpty)
  );

  assign w_srcHs    = r_srcValid && src_ready_i;
  assign w_snkHs    = r_snkValid && snk_ready_i;
  assign w_bothDone = (r_srcDone || w_srcHs) && (r_snkDone || w_snkHs);
  assign w_remNext  = r_rem - r_chunkLen;
  assign w_stride   = ADDR_W'(r_chunkLen) << ELEM_SHIFT;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_rstDone <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_rstDone <= 1'b1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:    if (!w_fifoEmpty) w_stateNext = LOAD;
      LOAD:    w_stateNext = (r_rem == '0) ? DONE : ISSUE;
      ISSUE:   if (w_bothDone) w_stateNext = RUN;
      RUN:     if (eng_done_i) w_stateNext = (w_remNext == '0) ? DONE : ISSUE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (clear_i) w_stateNext = IDLE;
  end

  always_comb begin
    evt_done_o  = (r_state == DONE);
    busy_o      = (r_state != IDLE) || !w_fifoEmpty;
    eng_start_o = r_engStart;
  end

  // Datapath: valids/len are set on every entry into ISSUE; addresses advance on each engine done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rem       <= '0;
      r_chunkLen  <= '0;
      r_srcAddr   <= '0;
      r_snkAddr   <= '0;
      r_operand   <= '0;
      r_operation <= '0;
      r_srcValid  <= 1'b0;
      r_snkValid  <= 1'b0;
      r_srcDone   <= 1'b0;
      r_snkDone   <= 1'b0;
      r_engStart  <= 1'b0;
    end else if (clear_i) begin
      r_srcValid  <= 1'b0;
      r_snkValid  <= 1'b0;
      r_srcDone   <= 1'b0;
      r_snkDone   <= 1'b0;
      r_engStart  <= 1'b0;
    end else begin
      r_engStart <= 1'b0;
      case (r_state)
        IDLE: if (!w_fifoEmpty) begin
          r_rem       <= LEN_W'(w_fifoHead.len);
          r_srcAddr   <= ADDR_W'(w_fifoHead.in_addr);
          r_snkAddr   <= ADDR_W'(w_fifoHead.out_addr);
          r_operand   <= w_fifoHead.operand;
          r_operation <= w_fifoHead.operation;
        end
        LOAD: if (r_rem != '0) begin
          r_chunkLen <= f_chunk(r_rem);
          r_srcValid <= 1'b1;
          r_snkValid <= 1'b1;
          r_srcDone  <= 1'b0;
          r_snkDone  <= 1'b0;
        end
        ISSUE: begin
          if (w_srcHs) begin
            r_srcValid <= 1'b0;
            r_srcDone  <= 1'b1;
          end
          if (w_snkHs) begin
            r_snkValid <= 1'b0;
            r_snkDone  <= 1'b1;
          end
          if (w_bothDone) r_engStart <= 1'b1;
        end
        RUN: if (eng_done_i) begin
          r_rem     <= w_remNext;
          r_srcAddr <= r_srcAddr + w_stride;
          r_snkAddr <= r_snkAddr + w_stride;
          if (w_remNext != '0) begin
            r_chunkLen <= f_chunk(w_remNext);
            r_srcValid <= 1'b1;
            r_snkValid <= 1'b1;
            r_srcDone  <= 1'b0;
            r_snkDone  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign src_valid_o     = r_srcValid;
  assign snk_valid_o     = r_snkValid;
  assign src_addr_o      = r_srcAddr;
  assign snk_addr_o      = r_snkAddr;
  assign chunk_len_o     = r_chunkLen;
  assign eng_operand_o   = r_operand;
  assign eng_operation_o = r_operation;

`ifdef SMMHA_JOB_PERF_EN
  logic [31:0] r_perfCycles;
  logic [15:0] r_perfChunks;

  // Counters restart at LOAD and freeze in IDLE so the last job's figures stay readable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perfCycles <= '0;
      r_perfChunks <= '0;
    end else if (r_state == LOAD) begin
      r_perfCycles <= '0;
      r_perfChunks <= '0;
    end else if (r_state != IDLE) begin
      if (r_perfCycles != '1) r_perfCycles <= r_perfCycles + 1'b1;
      if (r_engStart) r_perfChunks <= r_perfChunks + 1'b1;
    end
  end

  assign perf_cycles_o = r_perfCycles;
  assign perf_chunks_o = r_perfChunks;
`endif

endmodule
